// File: rtl/fa_serial_ctrl.sv
// Bit-serial adder controller: one full-adder slice sequenced LSB-first over WIDTH bits.
// Optional subtract mode (sub port, B inverted with carry-in forced to 1) under `define FA_SERIAL_SUB_EN.
module fa_serial_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef FA_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_s_sr;
    logic [WIDTH-1:0]   w_s_shift;
    logic [WIDTH-1:0]   w_b_load;
    logic [CNT_W-1:0]   r_count;
    logic               r_carry;
    logic               w_s;
    logic               w_c_next;
    logic               w_c_load;
    logic               w_last;
    logic               w_accept;

    // Full-adder slice on the shift-register LSBs
    assign w_s       = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
    assign w_c_next  = (r_a_sr[0] & r_b_sr[0]) | (r_b_sr[0] & r_carry) | (r_carry & r_a_sr[0]);
    assign w_s_shift = {w_s, r_s_sr[WIDTH-1:1]};
    assign w_last    = (r_count == CNT_W'(WIDTH - 1));
    assign w_accept  = (r_state == S_IDLE) && start;

`ifdef FA_SERIAL_SUB_EN
    assign w_b_load = sub ? ~b : b;
    assign w_c_load = sub ? 1'b1 : cin;
`else
    assign w_b_load = b;
    assign w_c_load = cin;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Status flags registered from the next state so they track r_state exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            ready <= (w_state_next == S_IDLE);
            busy  <= (w_state_next == S_RUN);
            done  <= (w_state_next == S_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_s_sr  <= '0;
            r_carry <= 1'b0;
            r_count <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else if (w_accept) begin
            r_a_sr  <= a;
            r_b_sr  <= w_b_load;
            r_s_sr  <= '0;
            r_carry <= w_c_load;
            r_count <= '0;
        end else if (r_state == S_RUN) begin
            r_a_sr  <= r_a_sr >> 1;
            r_b_sr  <= r_b_sr >> 1;
            r_s_sr  <= w_s_shift;
            r_carry <= w_c_next;
            r_count <= r_count + CNT_W'(1);
            if (w_last) begin
                sum  <= w_s_shift;
                cout <= w_c_next;
            end
        end
    end

endmodule

// File: tb/tb_fa_serial_ctrl.sv
// Scoreboard bench for fa_serial_ctrl: WIDTH=8 directed cases plus an exhaustive WIDTH=4 sweep.
module tb_fa_serial_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, cin, sub;
    logic [7:0] a, b;
    logic       ready, busy, done, cout;
    logic [7:0] sum;

    logic       start4, cin4, sub4;
    logic [3:0] a4, b4;
    logic       ready4, busy4, done4, cout4;
    logic [3:0] sum4;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;
    int unsigned done_cnt8 = 0;
    int unsigned done_cnt4 = 0;

    typedef struct {
        logic [8:0]  res;
        int unsigned cyc;
    } exp8_t;

    exp8_t      q8[$];
    logic [4:0] q4[$];
    logic [8:0] last8;
    logic [4:0] last4;
    logic       prev_done8;

    fa_serial_ctrl #(.WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
`ifdef FA_SERIAL_SUB_EN
        .sub(sub),
`endif
        .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    fa_serial_ctrl #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
`ifdef FA_SERIAL_SUB_EN
        .sub(sub4),
`endif
        .ready(ready4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y,
                                          input logic c, input logic s);
        if (s) return {(x >= y) ? 1'b1 : 1'b0, 8'(x - y)};
        return 9'(x) + 9'(y) + 9'(c);
    endfunction

    // WIDTH=8 scoreboard: push on accept, pop and compare on done
    always @(negedge clk) begin
        if (!rst_n) begin
            q8.delete();
            last8      = '0;
            prev_done8 = 1'b0;
        end else begin
            check("onehot8", 64'($countones({ready, busy, done})), 64'(1));
            if (done) begin
                exp8_t e;
                done_cnt8++;
                if (q8.size() == 0) begin
                    check("done_unexpected8", 64'(1), 64'(0));
                end else begin
                    e = q8.pop_front();
                    check("result8", 64'({cout, sum}), 64'(e.res));
                    check("latency8", 64'(cyc), 64'(e.cyc));
                end
                last8 = {cout, sum};
            end else begin
                check("hold8", 64'({cout, sum}), 64'(last8));
            end
            if (prev_done8) check("ready_after_done8", 64'(ready), 64'(1));
            prev_done8 = done;
            if (ready && start) begin
                exp8_t n;
                n.res = model8(a, b, cin, sub);
                n.cyc = cyc + 1 + 8;
                q8.push_back(n);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q4.delete();
            last4 = '0;
        end else begin
            if (done4) begin
                done_cnt4++;
                if (q4.size() == 0) check("done_unexpected4", 64'(1), 64'(0));
                else check("result4", 64'({cout4, sum4}), 64'(q4.pop_front()));
                last4 = {cout4, sum4};
            end else begin
                check("hold4", 64'({cout4, sum4}), 64'(last4));
            end
            if (ready4 && start4) q4.push_back(5'(a4) + 5'(b4) + 5'(cin4));
        end
    end

    task automatic wait_ready8();
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (ready) return;
        end
        check("ready_timeout8", 64'(0), 64'(1));
    endtask

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc, input logic ts);
        wait_ready8();
        a = ta; b = tb_v; cin = tc; sub = ts; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done8();
        int unsigned base;
        base = done_cnt8;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_cnt8 != base) return;
        end
        check("done_timeout8", 64'(0), 64'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(ready), 64'(1));
        check("rst_busy",  64'(busy),  64'(0));
        check("rst_done",  64'(done),  64'(0));
        check("rst_sum",   64'(sum),   64'(0));
        check("rst_cout",  64'(cout),  64'(0));
        #2 rst_n = 1'b1;

        op8(8'h5A, 8'h33, 1'b0, 1'b0);
        wait_done8();
        check("sum_5a_33", 64'(sum), 64'(8'h8D));
        check("cout_5a_33", 64'(cout), 64'(0));

        op8(8'hFF, 8'h01, 1'b0, 1'b0);
        wait_done8();
        check("sum_ff_01", 64'(sum), 64'(8'h00));
        check("cout_ff_01", 64'(cout), 64'(1));

        op8(8'hFF, 8'hFF, 1'b1, 1'b0);
        wait_done8();
        check("sum_ff_ff_c", 64'(sum), 64'(8'hFF));
        check("cout_ff_ff_c", 64'(cout), 64'(1));

        // start held high; operands scrambled whenever the block is not ready
        wait_ready8();
        base = done_cnt8;
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        repeat (30) begin
            @(posedge clk); #1;
            if (ready) begin
                a = 8'h01; b = 8'h02; cin = 1'b0;
            end else begin
                a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            end
        end
        start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (12) @(negedge clk);
        check("held_done_count", 64'(done_cnt8 - base), 64'(3));
        check("held_sum", 64'(sum), 64'(8'h03));

        // asynchronous abort after bit 3
        op8(8'h77, 8'h11, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_ready", 64'(ready), 64'(1));
        check("abort_busy",  64'(busy),  64'(0));
        check("abort_done",  64'(done),  64'(0));
        check("abort_sum",   64'(sum),   64'(0));
        check("abort_cout",  64'(cout),  64'(0));
        base = done_cnt8;
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("abort_no_done", 64'(done_cnt8), 64'(base));
        op8(8'h10, 8'h20, 1'b0, 1'b0);
        wait_done8();
        check("sum_10_20", 64'(sum), 64'(8'h30));

`ifdef FA_SERIAL_SUB_EN
        op8(8'h10, 8'h01, 1'b1, 1'b1);
        wait_done8();
        check("sub_10_01_sum", 64'(sum), 64'(8'h0F));
        check("sub_10_01_cout", 64'(cout), 64'(1));
        op8(8'h01, 8'h02, 1'b0, 1'b1);
        wait_done8();
        check("sub_01_02_sum", 64'(sum), 64'(8'hFF));
        check("sub_01_02_cout", 64'(cout), 64'(0));
        sub = 1'b0;
`endif
        repeat (12) @(negedge clk);
        check("q8_drained", 64'(q8.size()), 64'(0));

        // exhaustive WIDTH=4 sweep
        base = done_cnt4;
        for (int i = 0; i < 512; i++) begin
            for (int t = 0; t < 20; t++) begin
                @(posedge clk); #1;
                if (ready4) break;
                if (t == 19) check("ready_timeout4", 64'(0), 64'(1));
            end
            a4 = 4'(i); b4 = 4'(i >> 4); cin4 = 1'(i >> 8); start4 = 1'b1;
            @(posedge clk); #1;
            start4 = 1'b0;
            a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
        end
        repeat (12) @(negedge clk);
        check("w4_done_count", 64'(done_cnt4 - base), 64'(512));
        check("q4_drained", 64'(q4.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fa_serial_ctrl.md
# fa_serial_ctrl

Bit-serial adder controller that sequences a single one-bit full-adder slice over a WIDTH-bit operand pair, one bit per clock, LSB first. It owns the operand shift registers, the carry flip-flop, the bit counter and the start/done handshake. It trades WIDTH+2 cycles per operation for one full-adder cell, and sits wherever a narrow-area add is needed in place of a ripple-carry array.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only while ready=1
- a  in  WIDTH  operand A, captured on the accepting edge
- b  in  WIDTH  operand B, captured on the accepting edge
- cin  in  1  carry-in, captured on the accepting edge
- sub  in  1  subtract select; present only with FA_SERIAL_SUB_EN, captured on the accepting edge
- ready  out  1  high in IDLE
- busy  out  1  high in RUN
- done  out  1  one-cycle completion pulse
- sum  out  WIDTH  registered result, stable between completions
- cout  out  1  registered final carry

## Operation
- Internal full-adder slice: s = x^y^c; c_next = (x&y)|(y&c)|(c&x); x = A shift-register bit 0, y = B shift-register bit 0, c = carry flip-flop.
- FSM states: IDLE, RUN, DONE.
- IDLE: ready=1. On start=1, load A_sr<=a, B_sr<=b, carry<=cin, count<=0, then go to RUN. On start=0, stay in IDLE.
- RUN: busy=1. Each edge does the following:
  - shift the slice sum into the MSB of the internal S_sr;
  - shift A_sr and B_sr right by one;
  - carry<=c_next; count<=count+1.
  - When count==WIDTH-1, the same edge loads sum<=final S_sr value and cout<=c_next, and the FSM goes to DONE.
- DONE: done=1 for exactly one cycle, then the FSM returns to IDLE unconditionally.
- start is ignored in RUN and DONE. No queuing, no restart, and operands are not re-sampled.
- Counter width is $clog2(WIDTH) bits. It never wraps mid-operation because the FSM leaves RUN at WIDTH-1.
- sum and cout change only on the completion edge. They hold their value through IDLE and through the next RUN.
- Arithmetic result: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).

## Timing
- Reset values: ready=1, busy=0, done=0, sum=0, cout=0, state=IDLE, count=0, carry=0, all shift registers 0.
- Reset is asynchronous. Asserting it mid-operation immediately forces all reset values. The aborted operation produces no done pulse and leaves no stale sum.
- Latency: if start is accepted on edge E, bits 0..WIDTH-1 are processed on edges E+1..E+WIDTH.
  - done, sum and cout are valid after edge E+WIDTH.
  - ready rises after edge E+WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles. The earliest next accept is edge E+WIDTH+2 if start is held high.
- ready, busy and done are mutually exclusive and are decoded from the state register, with no combinational path from inputs.
- If start is held continuously, back-to-back operations run, each producing exactly one done pulse.

## Configuration
- FA_SERIAL_SUB_EN defined:
  - The sub port exists and is captured with the operands.
  - When sub=1, B_sr loads ~b and carry loads 1, ignoring cin. The result is a-b, and cout=1 means no borrow.
  - When sub=0, behaviour is identical to the undefined case.
- FA_SERIAL_SUB_EN undefined: the sub port is absent and the block is add-only.

## Test plan
- WIDTH=8, a=0x5A, b=0x33, cin=0, start pulsed -> done is high exactly 8 edges after the accept; sum=0x8D, cout=0; ready is high on the following cycle.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- start held high for 30 cycles with a=0x01, b=0x02 -> exactly 3 done pulses, each with sum=0x03. Operand changes during RUN do not affect the result.
- rst_n driven low after bit 3 of an operation -> all outputs are at reset values immediately and no done follows. A subsequent a=0x10, b=0x20 gives sum=0x30.
- With FA_SERIAL_SUB_EN:
  - a=0x10, b=0x01, sub=1 -> sum=0x0F, cout=1.
  - a=0x01, b=0x02, sub=1 -> sum=0xFF, cout=0.
- Exhaustive random check with WIDTH=4 over all a, b and cin values -> {cout,sum} always equals a+b+cin, and sum stays stable between done pulses.
